// File: rtl/seg_scan_capture.sv
// Captures a multiplexed 7-segment display bus and decodes each digit back to a hex nibble + dp.
// Define SEG_ACTIVE_LOW_EN for common-anode / low-side drivers (inputs inverted before sync).
module seg_scan_capture #(
    parameter int DIGITS = 4,
    parameter int SETTLE = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DIGITS-1:0]     an,
    input  logic [7:0]            seg,
    output logic [4*DIGITS-1:0]   hex,
    output logic [DIGITS-1:0]     valid,
    output logic [DIGITS-1:0]     dp,
    output logic                  frame_done,
    output logic                  bad_sel,
    output logic                  bad_pat
);

    localparam int W = DIGITS + 8;
    localparam logic [7:0] SETTLE_C = 8'(SETTLE);

    logic [W-1:0]      raw, s1, s2, s2_d;
    logic [7:0]        stable_cnt;
    logic [DIGITS-1:0] seen, seen_next;
    logic [DIGITS-1:0] cap_an;
    logic [7:0]        cap_seg;
    logic              strobe, multi, legal;
    logic [4:0]        lut;

`ifdef SEG_ACTIVE_LOW_EN
    assign raw = ~{an, seg};
`else
    assign raw = {an, seg};
`endif

    // Returns {legal, nibble}; blank and unknown patterns both report illegal.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h3F: decode = 5'h10;
            7'h06: decode = 5'h11;
            7'h5B: decode = 5'h12;
            7'h4F: decode = 5'h13;
            7'h66: decode = 5'h14;
            7'h6D: decode = 5'h15;
            7'h7D: decode = 5'h16;
            7'h07: decode = 5'h17;
            7'h7F: decode = 5'h18;
            7'h6F: decode = 5'h19;
            7'h77: decode = 5'h1A;
            7'h7C: decode = 5'h1B;
            7'h39: decode = 5'h1C;
            7'h5E: decode = 5'h1D;
            7'h79: decode = 5'h1E;
            7'h71: decode = 5'h1F;
            default: decode = 5'h00;
        endcase
    endfunction

    assign cap_an  = s2[W-1:8];
    assign cap_seg = s2[7:0];
    assign strobe  = (s2 == s2_d) && (stable_cnt == SETTLE_C - 8'd1);
    assign multi   = (cap_an & (cap_an - DIGITS'(1))) != '0;
    assign lut     = decode(cap_seg[6:0]);
    assign legal   = lut[4];

    // A completed frame clears the mask one cycle later; a capture landing that cycle still counts.
    always_comb begin
        seen_next = (&seen) ? '0 : seen;
        if (strobe && !multi)
            seen_next = seen_next | cap_an;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1         <= '0;
            s2         <= '0;
            s2_d       <= '0;
            stable_cnt <= SETTLE_C;
            seen       <= '0;
            hex        <= '0;
            valid      <= '0;
            dp         <= '0;
            frame_done <= 1'b0;
            bad_sel    <= 1'b0;
            bad_pat    <= 1'b0;
        end else begin
            s1   <= raw;
            s2   <= s1;
            s2_d <= s2;
            if (s2 != s2_d)
                stable_cnt <= 8'd0;
            else if (stable_cnt != SETTLE_C)
                stable_cnt <= stable_cnt + 8'd1;

            frame_done <= &seen;
            bad_sel    <= 1'b0;
            bad_pat    <= 1'b0;
            seen       <= seen_next;

            if (strobe && cap_an != '0) begin
                if (multi) begin
                    bad_sel <= 1'b1;
                end else begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (cap_an[i]) begin
                            dp[i]    <= cap_seg[7];
                            valid[i] <= legal;
                            if (legal)
                                hex[4*i +: 4] <= lut[3:0];
                        end
                    end
                    if (!legal && cap_seg[6:0] != 7'h00)
                        bad_pat <= 1'b1;
                end
            end
        end
    end

endmodule
